// File: rtl/p2i_pkg.sv
// Types and constants shared between the clustering front end and project2image.
// Coordinates are s6c9f: sign bit, 6 integer bits, 9 fraction bits.
package p2i_pkg;

  localparam int INT_BITS  = 6;
  localparam int FRAC_BITS = 9;
  localparam int COORD_W   = 1 + INT_BITS + FRAC_BITS;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } point_t;

  typedef struct packed {
    coord_t min_x;
    coord_t min_y;
    coord_t min_z;
    coord_t max_x;
    coord_t max_y;
    coord_t max_z;
  } box_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/cluster_bbox_builder_if.sv
// Point-stream and box-stream handshake bundles of the bounding-box builder.
interface cbb_point_if #(parameter int W = 16);
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         last_in;

  modport master (output valid_in, x_in, y_in, z_in, last_in, input ready_out);
  modport slave  (input valid_in, x_in, y_in, z_in, last_in, output ready_out);
endinterface

interface cbb_box_if #(parameter int W = 16, parameter int CNT_W = 12);
  logic             valid_out;
  logic             ready_in;
  logic [W-1:0]     min_x;
  logic [W-1:0]     min_y;
  logic [W-1:0]     min_z;
  logic [W-1:0]     max_x;
  logic [W-1:0]     max_y;
  logic [W-1:0]     max_z;
  logic [CNT_W-1:0] point_cnt;

  modport master (output valid_out, min_x, min_y, min_z, max_x, max_y, max_z, point_cnt,
                  input ready_in);
  modport slave  (input valid_out, min_x, min_y, min_z, max_x, max_y, max_z, point_cnt,
                  output ready_in);
endinterface

// File: rtl/cluster_bbox_builder_axis_minmax.sv
// Signed min/max tracker for one axis; exposes the post-update value so the
// caller can capture a finished box in the same cycle as the last point.
module axis_minmax
  import p2i_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                update,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] min_nxt,
  output logic signed [W-1:0] max_nxt
);

  logic signed [W-1:0] min_r;
  logic signed [W-1:0] max_r;

  // Strict compares so ties keep the value already held.
  always_comb begin
    min_nxt = min_r;
    max_nxt = max_r;
    if (init) begin
      min_nxt = sample;
      max_nxt = sample;
    end else if (update) begin
      min_nxt = (sample < min_r) ? sample : min_r;
      max_nxt = (sample > max_r) ? sample : max_r;
    end else begin
      min_nxt = min_r;
      max_nxt = max_r;
    end
  end

  // Tracker state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= '0;
      max_r <= '0;
    end else begin
      min_r <= min_nxt;
      max_r <= max_nxt;
    end
  end

endmodule

// File: rtl/cluster_bbox_builder.sv
// Accumulates per-cluster axis-aligned boxes from a point stream and presents
// each surviving cluster's box on a valid/ready handshake.
module cluster_bbox_builder
  import p2i_pkg::*;
#(
  parameter int W          = COORD_W,
  parameter int CNT_W      = 12,
  parameter int MIN_POINTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  cbb_point_if.slave  pt,
  cbb_box_if.master   bx,
  output logic        dropped
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_POINTS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt, box_cnt_r;
  logic               take, init, update, emit, drop, dropped_r;
  logic [2:0][W-1:0]  sample, mn_nxt, mx_nxt, bmin_r, bmax_r;

  assign take   = pt.valid_in && (state_r != OUT);
  assign sample = {pt.z_in, pt.y_in, pt.x_in};

  axis_minmax #(.W(W)) u_x (.clk(clk), .rst_n(rst_n), .init(init), .update(update),
                            .sample(sample[0]), .min_nxt(mn_nxt[0]), .max_nxt(mx_nxt[0]));
  axis_minmax #(.W(W)) u_y (.clk(clk), .rst_n(rst_n), .init(init), .update(update),
                            .sample(sample[1]), .min_nxt(mn_nxt[1]), .max_nxt(mx_nxt[1]));
  axis_minmax #(.W(W)) u_z (.clk(clk), .rst_n(rst_n), .init(init), .update(update),
                            .sample(sample[2]), .min_nxt(mn_nxt[2]), .max_nxt(mx_nxt[2]));

  // Next state, counter and last-point decision.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    init      = 1'b0;
    update    = 1'b0;
    emit      = 1'b0;
    drop      = 1'b0;
    case (state_r)
      IDLE: begin
        if (take) begin
          init      = 1'b1;
          cnt_nxt   = CNT_ONE;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (take) begin
          update  = 1'b1;
          cnt_nxt = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      OUT: begin
        if (bx.ready_in) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OUT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take && pt.last_in) begin
      if (cnt_nxt >= MIN_CNT) begin
        emit      = 1'b1;
        state_nxt = OUT;
      end else begin
        drop      = 1'b1;
        state_nxt = IDLE;
      end
    end else begin
      emit = 1'b0;
    end
  end

  // FSM state, point counter and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      dropped_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      dropped_r <= drop;
    end
  end

  // Box registers change only when a cluster is emitted, so they stay stable in OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmin_r    <= '0;
      bmax_r    <= '0;
      box_cnt_r <= '0;
    end else if (emit) begin
      bmin_r    <= mn_nxt;
      bmax_r    <= mx_nxt;
      box_cnt_r <= cnt_nxt;
    end
  end

  assign pt.ready_out = (state_r != OUT);
  assign bx.valid_out = (state_r == OUT);
  assign bx.min_x     = bmin_r[0];
  assign bx.min_y     = bmin_r[1];
  assign bx.min_z     = bmin_r[2];
  assign bx.max_x     = bmax_r[0];
  assign bx.max_y     = bmax_r[1];
  assign bx.max_z     = bmax_r[2];
  assign bx.point_cnt = box_cnt_r;
  assign dropped      = dropped_r;

endmodule

// File: tb/tb_cluster_bbox_builder.sv
// Directed and randomised checks of cluster_bbox_builder with MIN_POINTS=1 and =4.
module tb_cluster_bbox_builder;

  logic clk = 1'b0;
  logic rst_n;
  logic drop1, drop4;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cbb_point_if #(.W(16))             p1 ();
  cbb_point_if #(.W(16))             p4 ();
  cbb_box_if   #(.W(16), .CNT_W(12)) b1 ();
  cbb_box_if   #(.W(16), .CNT_W(12)) b4 ();

  cluster_bbox_builder #(.W(16), .CNT_W(12), .MIN_POINTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pt(p1), .bx(b1), .dropped(drop1));
  cluster_bbox_builder #(.W(16), .CNT_W(12), .MIN_POINTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pt(p4), .bx(b4), .dropped(drop4));

  function automatic logic [107:0] get_box(input bit s);
    if (s) return {b4.min_x, b4.min_y, b4.min_z, b4.max_x, b4.max_y, b4.max_z, b4.point_cnt};
    else   return {b1.min_x, b1.min_y, b1.min_z, b1.max_x, b1.max_y, b1.max_z, b1.point_cnt};
  endfunction

  task automatic drive(input bit s, input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic l);
    if (s) begin
      p4.valid_in = v; p4.x_in = x; p4.y_in = y; p4.z_in = z; p4.last_in = l;
    end else begin
      p1.valid_in = v; p1.x_in = x; p1.y_in = y; p1.z_in = z; p1.last_in = l;
    end
  endtask

  task automatic push(input bit s, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic l);
    drive(s, 1'b1, x, y, z, l);
    @(negedge clk);
  endtask

  task automatic consume(input bit s);
    if (s) b4.ready_in = 1'b1; else b1.ready_in = 1'b1;
    @(negedge clk);
    b4.ready_in = 1'b0;
    b1.ready_in = 1'b0;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    b1.ready_in = 1'b0;
    b4.ready_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (b4.valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", b4.valid_out); end
    checks++; if (drop4 !== 1'b0) begin errs++; $display("FAIL reset_dropped got=%b exp=0", drop4); end
    checks++; if (get_box(1'b1) !== 108'h0) begin errs++; $display("FAIL reset_box4 got=%h exp=0", get_box(1'b1)); end
    checks++; if (get_box(1'b0) !== 108'h0) begin errs++; $display("FAIL reset_box1 got=%h exp=0", get_box(1'b0)); end
    checks++; if (p4.ready_out !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", p4.ready_out); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_point;
    logic [107:0] exp_box = {16'h0800, 16'hFC00, 16'hFC00, 16'h0C00, 16'h0400, 16'h0000, 12'd2};
    push(1'b0, 16'h0800, 16'hFC00, 16'hFC00, 1'b0);
    drive(1'b0, 1'b1, 16'h0C00, 16'h0400, 16'h0000, 1'b1);
    checks++; if (b1.valid_out !== 1'b0) begin errs++; $display("FAIL two_pt_early got=%b exp=0", b1.valid_out); end
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (b1.valid_out !== 1'b1) begin errs++; $display("FAIL two_pt_valid got=%b exp=1", b1.valid_out); end
    checks++; if (get_box(1'b0) !== exp_box) begin errs++; $display("FAIL two_pt_box got=%h exp=%h", get_box(1'b0), exp_box); end
    consume(1'b0);
    checks++; if (b1.valid_out !== 1'b0) begin errs++; $display("FAIL two_pt_done got=%b exp=0", b1.valid_out); end
    checks++; if (p1.ready_out !== 1'b1) begin errs++; $display("FAIL two_pt_ready got=%b exp=1", p1.ready_out); end
  endtask

  task automatic test_signed_extremes;
    logic [107:0] exp_box = {16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 12'd2};
    push(1'b0, 16'h7FFF, 16'h0000, 16'h0000, 1'b0);
    push(1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (get_box(1'b0) !== exp_box) begin errs++; $display("FAIL signed_box got=%h exp=%h", get_box(1'b0), exp_box); end
    consume(1'b0);
  endtask

  task automatic test_backpressure;
    logic [107:0] exp_a = {16'h0008, 16'hFFF0, 16'h8001, 16'h0040, 16'h0100, 16'h0030, 12'd4};
    logic [107:0] exp_b = {16'h0100, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 12'd4};
    push(1'b1, 16'h0010, 16'h0020, 16'h0030, 1'b0);
    push(1'b1, 16'h0040, 16'hFFF0, 16'h0000, 1'b0);
    push(1'b1, 16'h0008, 16'h0100, 16'h0001, 1'b0);
    push(1'b1, 16'h0020, 16'h0000, 16'h8001, 1'b1);
    drive(1'b1, 1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (b4.valid_out !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, b4.valid_out); end
      checks++; if (p4.ready_out !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b exp=0", k, p4.ready_out); end
      checks++; if (get_box(1'b1) !== exp_a) begin errs++; $display("FAIL bp_box[%0d] got=%h exp=%h", k, get_box(1'b1), exp_a); end
      @(negedge clk);
    end
    consume(1'b1);
    checks++; if (b4.valid_out !== 1'b0) begin errs++; $display("FAIL bp_release got=%b exp=0", b4.valid_out); end
    checks++; if (p4.ready_out !== 1'b1) begin errs++; $display("FAIL bp_ready_after got=%b exp=1", p4.ready_out); end
    @(negedge clk);
    push(1'b1, 16'h0200, 16'h0000, 16'h0000, 1'b0);
    push(1'b1, 16'h0300, 16'h0000, 16'h0000, 1'b0);
    push(1'b1, 16'h0400, 16'h0000, 16'h0000, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (get_box(1'b1) !== exp_b) begin errs++; $display("FAIL bp_next_box got=%h exp=%h", get_box(1'b1), exp_b); end
    consume(1'b1);
  endtask

  task automatic test_drop;
    logic [107:0] exp_box = {16'hFFFB, 16'hFFFF, 16'hFFFE, 16'h0007, 16'h0002, 16'h0004, 12'd4};
    push(1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    push(1'b1, 16'h0002, 16'h0002, 16'h0002, 1'b0);
    push(1'b1, 16'h0003, 16'h0003, 16'h0003, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (drop4 !== 1'b1) begin errs++; $display("FAIL drop_pulse got=%b exp=1", drop4); end
    checks++; if (b4.valid_out !== 1'b0) begin errs++; $display("FAIL drop_valid got=%b exp=0", b4.valid_out); end
    @(negedge clk);
    checks++; if (drop4 !== 1'b0) begin errs++; $display("FAIL drop_width got=%b exp=0", drop4); end
    checks++; if (b4.valid_out !== 1'b0) begin errs++; $display("FAIL drop_valid2 got=%b exp=0", b4.valid_out); end
    push(1'b1, 16'h0005, 16'hFFFF, 16'h0000, 1'b0);
    push(1'b1, 16'hFFFB, 16'h0002, 16'h0003, 1'b0);
    push(1'b1, 16'h0007, 16'h0001, 16'hFFFE, 1'b0);
    push(1'b1, 16'h0000, 16'h0000, 16'h0004, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (b4.valid_out !== 1'b1) begin errs++; $display("FAIL four_valid got=%b exp=1", b4.valid_out); end
    checks++; if (drop4 !== 1'b0) begin errs++; $display("FAIL four_no_drop got=%b exp=0", drop4); end
    checks++; if (get_box(1'b1) !== exp_box) begin errs++; $display("FAIL four_box got=%h exp=%h", get_box(1'b1), exp_box); end
    consume(1'b1);
  endtask

  task automatic test_async_reset;
    logic [107:0] exp_box = {16'h0011, 16'h0022, 16'h0033, 16'h00AA, 16'h00BB, 16'h00CC, 12'd4};
    push(1'b1, 16'h1000, 16'h1000, 16'h1000, 1'b0);
    push(1'b1, 16'h2000, 16'h2000, 16'h2000, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (get_box(1'b1) !== 108'h0) begin errs++; $display("FAIL arst_box got=%h exp=0", get_box(1'b1)); end
    checks++; if (b4.valid_out !== 1'b0) begin errs++; $display("FAIL arst_valid got=%b exp=0", b4.valid_out); end
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 16'h0011, 16'h0022, 16'h0033, 1'b0);
    push(1'b1, 16'h0044, 16'h0055, 16'h0066, 1'b0);
    push(1'b1, 16'h0077, 16'h0088, 16'h0099, 1'b0);
    push(1'b1, 16'h00AA, 16'h00BB, 16'h00CC, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (get_box(1'b1) !== exp_box) begin errs++; $display("FAIL arst_new_box got=%h exp=%h", get_box(1'b1), exp_box); end
    consume(1'b1);
  endtask

  task automatic test_back_to_back;
    logic [47:0]  pq[$];
    bit           lq[$];
    logic [107:0] eq[$];
    logic [107:0] e;
    logic signed [15:0] x, y, z, mnx, mny, mnz, mxx, mxy, mxz;
    int n, n_emit, n_drop, idx, cyc, bubbles, got_drop, boxes;
    n_emit = 0; n_drop = 0;
    for (int c = 0; c < 1000; c++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
        if (i == 0) begin
          mnx = x; mny = y; mnz = z; mxx = x; mxy = y; mxz = z;
        end else begin
          if (x < mnx) mnx = x;
          if (y < mny) mny = y;
          if (z < mnz) mnz = z;
          if (x > mxx) mxx = x;
          if (y > mxy) mxy = y;
          if (z > mxz) mxz = z;
        end
        pq.push_back({x, y, z});
        lq.push_back(i == n - 1);
      end
      if (n >= 4) begin
        eq.push_back({mnx, mny, mnz, mxx, mxy, mxz, 12'(n)});
        n_emit++;
      end else begin
        n_drop++;
      end
    end
    b4.ready_in = 1'b1;
    idx = 0; cyc = 0; bubbles = 0; got_drop = 0; boxes = 0;
    while ((idx < pq.size() || eq.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (b4.valid_out) begin
        boxes++;
        checks++;
        if (eq.size() == 0) begin
          errs++; $display("FAIL b2b_extra_box got=%h exp=none", get_box(1'b1));
        end else begin
          e = eq.pop_front();
          if (get_box(1'b1) !== e) begin errs++; $display("FAIL b2b_box[%0d] got=%h exp=%h", boxes, get_box(1'b1), e); end
        end
      end
      if (drop4) got_drop++;
      if (!p4.ready_out) bubbles++;
      if (idx < pq.size()) begin
        drive(1'b1, 1'b1, pq[idx][47:32], pq[idx][31:16], pq[idx][15:0], lq[idx]);
        if (p4.ready_out) idx++;
      end else begin
        drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
      end
    end
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (drop4) got_drop++;
      if (b4.valid_out) boxes++;
    end
    b4.ready_in = 1'b0;
    checks++; if (cyc >= 20000) begin errs++; $display("FAIL b2b_timeout got=%0d cycles exp<20000", cyc); end
    checks++; if (boxes !== n_emit) begin errs++; $display("FAIL b2b_box_count got=%0d exp=%0d", boxes, n_emit); end
    checks++; if (got_drop !== n_drop) begin errs++; $display("FAIL b2b_drops got=%0d exp=%0d", got_drop, n_drop); end
    checks++; if (bubbles !== n_emit) begin errs++; $display("FAIL b2b_bubbles got=%0d exp=%0d", bubbles, n_emit); end
  endtask

  initial begin
    test_reset();
    test_two_point();
    test_signed_extremes();
    test_backpressure();
    test_drop();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
